tmds_video_encoder: RTL and testbench

- Downstream stage of the background/window pixel renderer.
- Consumes its RGB332 pixel stream together with the hs/vs/blank timing at the pixel clock.
- Expands each channel to 8 bits and produces three 10-bit DVI/HDMI TMDS symbols per clock: DC-balanced video words during active video, control tokens during blanking.
- Feeds the 10:1 serializers in the video output block.

---
 rtl/tmds_video_encoder_pkg.sv | 53 +++++
 rtl/tmds_video_encoder_channel.sv | 116 +++++++++++
 rtl/tmds_video_encoder.sv | 67 ++++++
 tb/tb_tmds_video_encoder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tmds_video_encoder_pkg.sv
// Shared definitions for the TMDS video encoder: control tokens, pipeline
// depth, the per-channel stage-1 record and small helper functions.
package tmds_video_encoder_pkg;

   // Control-period tokens, indexed by {C1,C0}
   localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

   // Input-to-symbol latency in pixel clocks
   localparam int unsigned TMDS_LATENCY = 2;

   // Which DC-balance rule the second stage applies to a video word
   typedef enum logic [1:0] {
      DISP_CASE_A,
      DISP_CASE_B,
      DISP_CASE_C
   } disp_case_e;

   // Stage-1 register contents for one channel
   typedef struct packed {
      logic [8:0] q_m;
      logic [3:0] n1;
      logic [3:0] n0;
      logic       blank;
      logic       c0;
      logic       c1;
   } stage1_t;

   // Number of ones in an 8-bit word
   function automatic logic [3:0] popcount8(input logic [7:0] x);
      logic [3:0] n;
      n = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         n = n + {3'b000, x[i]};
      end
      return n;
   endfunction

   // Control token for a {C1,C0} pair
   function automatic logic [9:0] ctrl_token(input logic c1, input logic c0);
      logic [9:0] tok;
      case ({c1, c0})
         2'b00:   tok = CTRL_TOKEN_00;
         2'b01:   tok = CTRL_TOKEN_01;
         2'b10:   tok = CTRL_TOKEN_10;
         default: tok = CTRL_TOKEN_11;
      endcase
      return tok;
   endfunction

endpackage

// File: rtl/tmds_video_encoder_channel.sv
// One TMDS channel: transition-minimising stage followed by the
// DC-balancing stage with its own running disparity counter.
module tmds_channel_encoder
   import tmds_video_encoder_pkg::*;
(
   input  logic       clk,
   input  logic       nreset,
   input  logic [7:0] data,
   input  logic       c0,
   input  logic       c1,
   input  logic       blank,
   output logic [9:0] tmds
);

   // XOR/XNOR chain; bit 8 records which one was used (1 = XOR)
   function automatic logic [8:0] minimise(input logic [7:0] d, input logic use_xnor);
      logic [8:0] q;
      q    = '0;
      q[0] = d[0];
      for (int unsigned i = 1; i < 8; i++) begin
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      end
      q[8] = ~use_xnor;
      return q;
   endfunction

   logic [3:0]        d_ones;
   logic              use_xnor;
   logic [8:0]        q_m;
   logic [3:0]        q_ones;
   stage1_t           s1;

   logic signed [4:0] cnt;
   logic signed [4:0] cnt_next;
   logic signed [4:0] n1_s;
   logic signed [4:0] n0_s;
   logic signed [4:0] diff;
   logic              cnt_pos;
   logic              cnt_neg;
   disp_case_e        sel;
   logic [9:0]        sym_next;

   // Stage 1 combinational: choose XOR/XNOR and count ones of the result
   always_comb begin
      d_ones   = popcount8(data);
      use_xnor = (d_ones > 4'd4) || ((d_ones == 4'd4) && !data[0]);
      q_m      = minimise(data, use_xnor);
      q_ones   = popcount8(q_m[7:0]);
   end

   // Stage 1 register: q_m, its ones/zeros counts, and the timing bits
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         s1 <= '{q_m: '0, n1: '0, n0: '0, blank: 1'b1, c0: 1'b0, c1: 1'b0};
      end else begin
         s1 <= '{q_m: q_m, n1: q_ones, n0: 4'd8 - q_ones,
                 blank: blank, c0: c0, c1: c1};
      end
   end

   // Stage 2 combinational: DC-balance decision or control token
   always_comb begin
      n1_s     = signed'({1'b0, s1.n1});
      n0_s     = signed'({1'b0, s1.n0});
      diff     = n1_s - n0_s;
      cnt_pos  = !cnt[4] && (cnt != '0);
      cnt_neg  = cnt[4];
      sym_next = CTRL_TOKEN_00;
      cnt_next = '0;

      if ((cnt == '0) || (s1.n1 == s1.n0)) begin
         sel = DISP_CASE_A;
      end else if ((cnt_pos && (s1.n1 > s1.n0)) || (cnt_neg && (s1.n0 > s1.n1))) begin
         sel = DISP_CASE_B;
      end else begin
         sel = DISP_CASE_C;
      end

      if (s1.blank) begin
         sym_next = ctrl_token(s1.c1, s1.c0);
         cnt_next = '0;
      end else begin
         case (sel)
            DISP_CASE_A: begin
               sym_next = {~s1.q_m[8], s1.q_m[8],
                           s1.q_m[8] ? s1.q_m[7:0] : ~s1.q_m[7:0]};
               cnt_next = s1.q_m[8] ? (cnt + diff) : (cnt - diff);
            end
            DISP_CASE_B: begin
               sym_next = {1'b1, s1.q_m[8], ~s1.q_m[7:0]};
               cnt_next = cnt + (s1.q_m[8] ? 5'sd2 : 5'sd0) - diff;
            end
            DISP_CASE_C: begin
               sym_next = {1'b0, s1.q_m[8], s1.q_m[7:0]};
               cnt_next = cnt - (s1.q_m[8] ? 5'sd0 : 5'sd2) + diff;
            end
            default: begin
               sym_next = CTRL_TOKEN_00;
               cnt_next = '0;
            end
         endcase
      end
   end

   // Stage 2 register: output symbol and running disparity
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         tmds <= CTRL_TOKEN_00;
         cnt  <= '0;
      end else begin
         tmds <= sym_next;
         cnt  <= cnt_next;
      end
   end

endmodule

// File: rtl/tmds_video_encoder.sv
// RGB332 + sync/blank to three TMDS symbols per pixel clock.
// Expands colour to 8 bits per channel and applies optional sync inversion.
module tmds_video_encoder
   import tmds_video_encoder_pkg::*;
#(
   parameter logic INVERT_SYNC = 1'b0
)
(
   input  logic       clk,
   input  logic       nreset,
   input  logic [2:0] r,
   input  logic [2:0] g,
   input  logic [1:0] b,
   input  logic       hs,
   input  logic       vs,
   input  logic       blank,
   output logic [9:0] tmds_ch0,
   output logic [9:0] tmds_ch1,
   output logic [9:0] tmds_ch2
);

   logic [7:0] r8;
   logic [7:0] g8;
   logic [7:0] b8;
   logic       c0_sync;
   logic       c1_sync;

   // Bit-replicating colour expansion and sync polarity for channel 0
   always_comb begin
      r8      = {r, r, r[2:1]};
      g8      = {g, g, g[2:1]};
      b8      = {b, b, b, b};
      c0_sync = hs ^ INVERT_SYNC;
      c1_sync = vs ^ INVERT_SYNC;
   end

   tmds_channel_encoder u_ch0 (
      .clk    (clk),
      .nreset (nreset),
      .data   (b8),
      .c0     (c0_sync),
      .c1     (c1_sync),
      .blank  (blank),
      .tmds   (tmds_ch0)
   );

   tmds_channel_encoder u_ch1 (
      .clk    (clk),
      .nreset (nreset),
      .data   (g8),
      .c0     (1'b0),
      .c1     (1'b0),
      .blank  (blank),
      .tmds   (tmds_ch1)
   );

   tmds_channel_encoder u_ch2 (
      .clk    (clk),
      .nreset (nreset),
      .data   (r8),
      .c0     (1'b0),
      .c1     (1'b0),
      .blank  (blank),
      .tmds   (tmds_ch2)
   );

endmodule

// File: tb/tb_tmds_video_encoder.sv
// Directed bench for tmds_video_encoder: two instances (normal and inverted
// sync) driven from the same stimulus, hand-derived expected symbols.
module tb_tmds_video_encoder;
   import tmds_video_encoder_pkg::*;

   logic       clk;
   logic       nreset;
   logic [2:0] r;
   logic [2:0] g;
   logic [1:0] b;
   logic       hs;
   logic       vs;
   logic       blank;
   logic [9:0] ch0, ch1, ch2;
   logic [9:0] inv_ch0, inv_ch1, inv_ch2;

   int errors = 0;
   int checks = 0;

   tmds_video_encoder #(.INVERT_SYNC(1'b0)) dut (
      .clk      (clk),
      .nreset   (nreset),
      .r        (r),
      .g        (g),
      .b        (b),
      .hs       (hs),
      .vs       (vs),
      .blank    (blank),
      .tmds_ch0 (ch0),
      .tmds_ch1 (ch1),
      .tmds_ch2 (ch2)
   );

   tmds_video_encoder #(.INVERT_SYNC(1'b1)) dut_inv (
      .clk      (clk),
      .nreset   (nreset),
      .r        (r),
      .g        (g),
      .b        (b),
      .hs       (hs),
      .vs       (vs),
      .blank    (blank),
      .tmds_ch0 (inv_ch0),
      .tmds_ch1 (inv_ch1),
      .tmds_ch2 (inv_ch2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] rr, input logic [2:0] gg, input logic [1:0] bb,
                        input logic hh, input logic vv, input logic bl);
      r = rr; g = gg; b = bb; hs = hh; vs = vv; blank = bl;
   endtask

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [9:0] e2, input logic [9:0] e1,
                       input logic [9:0] e0);
      chk({tag, "/ch2"}, ch2, e2);
      chk({tag, "/ch1"}, ch1, e1);
      chk({tag, "/ch0"}, ch0, e0);
   endtask

   initial begin
      nreset = 1'b0;
      drive(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      chk3("reset", 10'h354, 10'h354, 10'h354);
      chk("reset/inv_ch0", inv_ch0, 10'h354);

      nreset = 1'b1;
      tick();
      chk3("post_reset1", 10'h354, 10'h354, 10'h354);
      tick();
      chk3("post_reset2", 10'h354, 10'h354, 10'h354);

      // hs=1 during blank: C=01 normally, C=10 when inverted
      drive(3'd0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b1);
      tick();
      chk("hs_lat1/ch0", ch0, 10'h354);
      tick();
      chk3("hs_tok", 10'h354, 10'h354, 10'h0AB);
      chk("hs_tok/inv_ch0", inv_ch0, 10'h154);
      chk("hs_tok/inv_ch1", inv_ch1, 10'h354);

      drive(3'd0, 3'd0, 2'd0, 1'b1, 1'b1, 1'b1);
      repeat (TMDS_LATENCY) tick();
      chk("hsvs_tok/ch0", ch0, 10'h2AB);
      chk("hsvs_tok/inv_ch0", inv_ch0, 10'h354);

      drive(3'd0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1);
      repeat (TMDS_LATENCY) tick();
      chk("vs_tok/ch0", ch0, 10'h154);
      chk("vs_tok/inv_ch0", inv_ch0, 10'h0AB);

      // black stream from cnt=0: A(-8), B(+2), C(-6), B(+4)
      drive(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk3("black_lat1", 10'h354, 10'h354, 10'h154);
      tick();
      chk3("black1", 10'h100, 10'h100, 10'h100);
      chk("black1/inv_ch0", inv_ch0, 10'h100);
      tick();
      chk3("black2", 10'h3FF, 10'h3FF, 10'h3FF);
      tick();
      chk3("black3", 10'h100, 10'h100, 10'h100);
      tick();
      chk3("black4", 10'h3FF, 10'h3FF, 10'h3FF);

      // single-cycle blank: cnt 4 -> C gives 0x100, then token, then Case A
      drive(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      tick();
      chk3("black5", 10'h100, 10'h100, 10'h100);
      drive(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk3("blank_pulse", 10'h354, 10'h354, 10'h354);
      tick();
      chk3("after_blank", 10'h100, 10'h100, 10'h100);

      // white stream (D=0xFF): A(-8), C(-2), C(+4), B(-4), C(+2)
      drive(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      repeat (TMDS_LATENCY) tick();
      drive(3'd7, 3'd7, 2'd3, 1'b0, 1'b0, 1'b0);
      tick();
      chk3("white_lat1", 10'h354, 10'h354, 10'h354);
      tick();
      chk3("white1", 10'h200, 10'h200, 10'h200);
      tick();
      chk3("white2", 10'h0FF, 10'h0FF, 10'h0FF);
      tick();
      chk3("white3", 10'h0FF, 10'h0FF, 10'h0FF);
      tick();
      chk3("white4", 10'h200, 10'h200, 10'h200);
      tick();
      chk3("white5", 10'h0FF, 10'h0FF, 10'h0FF);

      // mixed: r=5 -> R8=0xB6, q_m=0x38 (XNOR); g=0; b=2 -> B8=0xAA, q_m=0xCC
      drive(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
      repeat (TMDS_LATENCY) tick();
      drive(3'd5, 3'd0, 2'd2, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      chk3("mixed1", 10'h2C7, 10'h100, 10'h233);
      tick();
      chk3("mixed2", 10'h038, 10'h3FF, 10'h233);
      chk("mixed2/inv_ch0", inv_ch0, 10'h233);

      // asynchronous reset between clock edges
      #2;
      nreset = 1'b0;
      #1;
      chk3("async_rst", 10'h354, 10'h354, 10'h354);
      chk("async_rst/inv_ch0", inv_ch0, 10'h354);
      tick();
      chk3("rst_held", 10'h354, 10'h354, 10'h354);
      drive(3'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      nreset = 1'b1;
      tick();
      chk3("fill1", 10'h354, 10'h354, 10'h354);
      tick();
      chk3("resume", 10'h100, 10'h100, 10'h100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
